// File: rtl/custom_pipelined_unit_pkg.sv
// Shared definitions for the custom-0 execution unit.
//   CUSTOM0_OPCODE     major opcode recognised by the decode logic
//   custom_fn3_t       operation select carried in the fn3 field
//   custom_stage_t     one execution pipeline stage {valid, id, result}
//   custom_compute()   the single-cycle ALU used by the first stage
package custom_pipelined_unit_pkg;

    localparam logic [6:0] CUSTOM0_OPCODE     = 7'b0001011;
    localparam int         ID_W               = 3;
    localparam int         REGFILE_READ_PORTS = 2;
    localparam int         RS1                = 0;
    localparam int         RS2                = 1;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [2:0] {
        FN_ADD  = 3'b000,
        FN_SUB  = 3'b001,
        FN_XOR  = 3'b010,
        FN_SMIN = 3'b011,
        FN_SMAX = 3'b100,
        FN_ROTL = 3'b101,
        FN_UMIN = 3'b110,
        FN_PASS = 3'b111
    } custom_fn3_t;

    typedef struct packed {
        logic        valid;
        id_t         id;
        logic [31:0] result;
    } custom_stage_t;

    function automatic logic [31:0] custom_compute(input logic [2:0]  fn3,
                                                   input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input logic        rotate_en);
        logic [31:0] r;
        case (custom_fn3_t'(fn3))
            FN_ADD:  r = a + b;
            FN_SUB:  r = a - b;
            FN_XOR:  r = a ^ b;
            FN_SMIN: r = ($signed(a) < $signed(b)) ? a : b;
            FN_SMAX: r = ($signed(a) > $signed(b)) ? a : b;
            // A shift distance of zero gives a >> 32, which is zero, so the
            // rotate degenerates to a plain copy of a as it should.
            FN_ROTL: r = rotate_en ? ((a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]})))
                                   : (a + b);
            FN_UMIN: r = (a < b) ? a : b;
            FN_PASS: r = a;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/custom_pipelined_unit_if.sv
// Issue / writeback bundle between the core and the custom-0 unit.
//   issue_*, rs1/rs2_data, wb_ack : driven by the core (master)
//   issue_ready, wb_*             : driven by the unit (slave)
interface custom_pipelined_unit_if import custom_pipelined_unit_pkg::*; ();

    logic        issue_new_request;
    id_t         issue_id;
    logic [2:0]  issue_fn3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_ready;
    logic        wb_done;
    logic [31:0] wb_rd;
    id_t         wb_id;
    logic        wb_ack;

    modport master (
        output issue_new_request, issue_id, issue_fn3, rs1_data, rs2_data, wb_ack,
        input  issue_ready, wb_done, wb_rd, wb_id
    );

    modport slave (
        input  issue_new_request, issue_id, issue_fn3, rs1_data, rs2_data, wb_ack,
        output issue_ready, wb_done, wb_rd, wb_id
    );

endinterface

// File: rtl/custom_pipelined_unit_result_fifo.sv
// Generic circular FIFO holding finished results.
//   clk, rst      clock, synchronous active-high reset (pointers/occupancy only)
//   push_i        write push_data_i at the tail
//   pop_i         advance the head; ignored while empty
//   head_o        entry at the head (valid while count_o != 0)
//   count_o       current occupancy
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module custom_pipelined_unit_result_fifo #(
    parameter int DATA_WIDTH = 35,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     pop_i,
    output logic [DATA_WIDTH-1:0]    head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_ok};
        end
    end

    // Storage is left unreset; only occupancy says what is meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/custom_pipelined_unit.sv
// Custom-0 execution unit: decode, fixed-latency ALU pipeline, result FIFO
// and credit-based issue flow control.
//   clk, rst                 clock, synchronous active-high reset
//   decode_instruction       instruction being decoded
//   unit_needed/uses_rs/uses_rd  decode outputs for custom-0
//   bus (slave)              issue request/operands, writeback head/ack
module custom_pipelined_unit import custom_pipelined_unit_pkg::*; #(
    parameter int LATENCY       = 2,
    parameter int RESULT_DEPTH  = 4,
    parameter int ENABLE_ROTATE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   decode_instruction,
    output logic                          unit_needed,
    output logic [REGFILE_READ_PORTS-1:0] uses_rs,
    output logic                          uses_rd,
    custom_pipelined_unit_if.slave        bus
);

    localparam int CW = $clog2(RESULT_DEPTH) + 1;

    // ---------------- decode ----------------
    logic unused_decode_bits;
    assign unused_decode_bits = ^decode_instruction[31:7];

    always_comb begin
        unit_needed  = (decode_instruction[6:0] == CUSTOM0_OPCODE);
        uses_rs      = '0;
        uses_rs[RS1] = unit_needed;
        uses_rs[RS2] = unit_needed;
        uses_rd      = unit_needed;
    end

    // ---------------- execution pipeline ----------------
    custom_stage_t stage_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q[0].valid <= 1'b0;
        end else begin
            stage_q[0] <= '{valid:  bus.issue_new_request,
                            id:     bus.issue_id,
                            result: custom_compute(bus.issue_fn3, bus.rs1_data,
                                                   bus.rs2_data, ENABLE_ROTATE != 0)};
        end
    end

    // Remaining stages only delay; the pipeline never stalls because credits
    // guarantee the FIFO has room for everything in flight.
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_delay
            always_ff @(posedge clk) begin
                if (rst) stage_q[gi].valid <= 1'b0;
                else     stage_q[gi]       <= stage_q[gi-1];
            end
        end
    endgenerate

    // ---------------- result FIFO ----------------
    logic                   pop;
    logic [ID_W+31:0]       fifo_head;
    logic [CW-1:0]          fifo_count;

    assign pop = bus.wb_ack && bus.wb_done;

    custom_pipelined_unit_result_fifo #(
        .DATA_WIDTH (ID_W + 32),
        .DEPTH      (RESULT_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (stage_q[LATENCY-1].valid),
        .push_data_i ({stage_q[LATENCY-1].id, stage_q[LATENCY-1].result}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign bus.wb_done = (fifo_count != '0);
    assign {bus.wb_id, bus.wb_rd} = fifo_head;

    // ---------------- credits ----------------
    // Counts everything issued but not yet consumed, so a pipeline push can
    // never find the FIFO full.
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;

    always_comb begin
        credit_d = credit_q;
        case ({bus.issue_new_request, pop})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) credit_q <= '0;
        else     credit_q <= credit_d;
    end

    assign bus.issue_ready = (credit_q < CW'(RESULT_DEPTH));

    issue_without_credit: assert property (@(posedge clk) disable iff (rst)
        !(bus.issue_new_request && !bus.issue_ready));

endmodule
